// File: rtl/wide_addsub_sequencer.sv
// wide_addsub_sequencer
// Drives an external combinational 4-bit adder slice one nibble per cycle,
// LSB first, chaining the carry, to perform a WIDTH-bit add or subtract.
// Subtraction is done as A + ~B + 1, so the final carry means "no borrow".
// The assembled result, carry-out and signed overflow are presented on a
// valid/ready output and held until the consumer takes them.
module wide_addsub_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_sum,
  input  logic             slice_cout
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [IDXW-1:0]   idx;
  logic              carry;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  beff_q;
  logic [WIDTH-1:0]  res_q;
  logic              cout_q;
  logic              ovf_q;
  logic              last_nib;
  logic [IDXW+1:0]   bitpos;

  // Two's-complement overflow: operands of equal sign giving a sum of the
  // other sign. The effective B (already inverted for subtract) is used so
  // the same rule covers both operations.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign last_nib = (idx == LAST_IDX);
  assign bitpos   = {idx, 2'b00};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode, handshake flags and slice drive
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    slice_a   = 4'd0;
    slice_b   = 4'd0;
    slice_cin = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        slice_a   = a_q[bitpos +: 4];
        slice_b   = beff_q[bitpos +: 4];
        slice_cin = carry;
        if (last_nib) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture at the accepting edge; plain data, no reset needed
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && in_valid) begin
      a_q    <= in_a;
      beff_q <= in_sub ? ~in_b : in_b;
    end
  end

  // Nibble sequencing: collect slice sums, chain carry, capture final flags
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry <= in_sub;
            idx   <= '0;
            res_q <= '0;
          end
        end
        RUN: begin
          res_q[bitpos +: 4] <= slice_sum;
          carry              <= slice_cout;
          idx                <= idx + 1'b1;
          if (last_nib) begin
            cout_q <= slice_cout;
            ovf_q  <= signed_ovf(a_q[WIDTH-1], beff_q[WIDTH-1], slice_sum[3]);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_result = res_q;
  assign out_cout   = cout_q;
  assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_wide_addsub_sequencer.sv
// Testbench for wide_addsub_sequencer (WIDTH=16) with a behavioural model of
// the 4-bit slice and an arithmetic reference for the full-width result.
module tb_wide_addsub_sequencer;

  localparam int WIDTH  = 16;
  localparam int NSLICE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
  logic             out_ovf;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic             slice_cin;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Combinational 4-bit adder slice
  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, slice_cin};

  wide_addsub_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_ovf    (out_ovf),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sum  (slice_sum),
    .slice_cout (slice_cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet_slices(input string tag);
    check({tag, "_sa"}, {28'd0, slice_a}, 32'd0);
    check({tag, "_sb"}, {28'd0, slice_b}, 32'd0);
    check({tag, "_sc"}, {31'd0, slice_cin}, 32'd0);
  endtask

  // Full transaction: accept, watch each RUN nibble, check result, stall, release
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input int stall, input bit noisy);
    logic [15:0] beff;
    logic [15:0] eres;
    logic        ecout;
    logic        eovf;
    logic [16:0] part;
    logic [16:0] mask;
    int          ra, rb, rs;
    int          waitc;
    beff  = sub ? ~b : b;
    ra    = int'($signed(a));
    rb    = int'($signed(b));
    rs    = sub ? (ra - rb) : (ra + rb);
    eovf  = (rs > 32767) || (rs < -32768);
    eres  = sub ? 16'(a - b) : 16'(a + b);
    ecout = sub ? (a >= b) : ((int'(a) + int'(b)) > 65535);

    waitc = 0;
    while (!in_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    check("out_valid_idle", {31'd0, out_valid}, 32'd0);

    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    tick();
    in_valid = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    in_sub   = 1'($urandom);

    for (int k = 0; k < NSLICE; k++) begin
      mask = (17'd1 << (4 * k)) - 17'd1;
      part = ({1'b0, a} & mask) + ({1'b0, beff} & mask) + {16'd0, sub};
      check("run_sa", {28'd0, slice_a}, {28'd0, a[4*k +: 4]});
      check("run_sb", {28'd0, slice_b}, {28'd0, beff[4*k +: 4]});
      check("run_cin", {31'd0, slice_cin}, {31'd0, part[4*k]});
      check("run_out_valid", {31'd0, out_valid}, 32'd0);
      check("run_in_ready", {31'd0, in_ready}, 32'd0);
      if (noisy) in_valid = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;

    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    check("result", {16'd0, out_result}, {16'd0, eres});
    check("cout", {31'd0, out_cout}, {31'd0, ecout});
    check("ovf", {31'd0, out_ovf}, {31'd0, eovf});
    check("done_in_ready", {31'd0, in_ready}, 32'd0);
    check_quiet_slices("done");

    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      if (noisy) begin
        in_valid = 1'($urandom);
        in_a     = 16'($urandom);
      end
      tick();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_result", {16'd0, out_result}, {16'd0, eres});
      check("stall_flags", {30'd0, out_cout, out_ovf}, {30'd0, ecout, eovf});
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'($urandom);
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    rst      = 1'b0;

    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {16'd0, out_result}, 32'd0);
    check("rst_flags", {30'd0, out_cout, out_ovf}, 32'd0);
    check_quiet_slices("rst");

    do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'hC000, 16'h6000, 1'b1, 0, 1'b0);
    do_op(16'h0003, 16'h0005, 1'b1, 1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1, 2, 1'b0);
    do_op(16'h1234, 16'h1234, 1'b1, 0, 1'b0);
    do_op(16'hA5A5, 16'h5A5A, 1'b0, 3, 1'b1);

    // Reset while RUN is on nibble 2 abandons the operation
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 16'hFFFF;
    in_b      = 16'hFFFF;
    in_sub    = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_run_busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_result", {16'd0, out_result}, 32'd0);
    check_quiet_slices("mrst");
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mrst_no_output", {31'd0, out_valid}, 32'd0);
    end
    do_op(16'h1234, 16'h1111, 1'b0, 0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
            1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
